// File: rtl/onescount_burst_ctrl.sv
// Counts the ones in 7-bit words over a burst of WORDS words (or up to an early flush) and
// returns the total and the word count. Define ONESCOUNT_SAT_EN to saturate the accumulator
// instead of letting it wrap.
module onescount_burst_ctrl #(
  parameter int WORDS = 4,
  parameter int ACC_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [6:0]       in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [ACC_W-1:0] sum,
  output logic [3:0]       sum_words,
  output logic [1:0]       state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Valid does not depend on ready. A producer holds its data and valid until the transfer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       pc;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic             accept;

  always_comb begin
    pc = 3'd0;
    for (int i = 0; i < 7; i++) pc = pc + 3'(in_data[i]);
  end

  // acc_sum is one bit wider than the accumulator, so its top bit flags an overflow.
  assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(pc);
`ifdef ONESCOUNT_SAT_EN
  assign acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
  assign acc_next = acc_sum[ACC_W-1:0];
`endif

  assign in_ready  = (state_q != OUTPUT);
  assign accept    = in_valid && in_ready;
  assign sum_valid = (state_q == OUTPUT);
  assign sum       = sum_valid ? acc_q : '0;
  assign sum_words = sum_valid ? cnt_q : 4'd0;
  assign state_o   = state_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // flush is ignored here: there is no burst to close yet.
        if (accept) begin
          acc_d   = ACC_W'(pc);
          cnt_d   = 4'd1;
          state_d = (WORDS == 1) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_next;
          cnt_d = cnt_q + 4'd1;
          if ((cnt_q + 4'd1 == 4'(WORDS)) || flush) state_d = OUTPUT;
        end else if (flush) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (sum_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_onescount_burst_ctrl.sv
// Directed plus random bench for onescount_burst_ctrl. Expected {sum, words} pairs go into a
// queue when a burst is driven and are popped when the block presents a result.
module tb_onescount_burst_ctrl;

  localparam int ACC_W = 5;
  localparam int W     = ACC_W + 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [6:0]       in_data;
  logic             in_ready;
  logic             flush;
  logic             sum_valid;
  logic             sum_ready;
  logic [ACC_W-1:0] sum;
  logic [3:0]       sum_words;
  logic [1:0]       state_o;

  // A second instance with a narrow accumulator shares the same stimulus.
  logic       s_in_ready, s_sum_valid;
  logic [3:0] s_sum, s_sum_words;
  logic [1:0] s_state;

  logic [W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  onescount_burst_ctrl #(.WORDS(4), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .sum_valid(sum_valid), .sum_ready(sum_ready), .sum(sum),
    .sum_words(sum_words), .state_o(state_o)
  );

  onescount_burst_ctrl #(.WORDS(4), .ACC_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .flush(flush), .sum_valid(s_sum_valid), .sum_ready(sum_ready), .sum(s_sum),
    .sum_words(s_sum_words), .state_o(s_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_word(input logic [6:0] d, input logic fl);
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    step();
    in_valid = 1'b0;
    in_data  = 7'd0;
    flush    = 1'b0;
  endtask

  function automatic logic [W-1:0] pack(input int s, input int n);
    return {ACC_W'(s), 4'(n)};
  endfunction

  // Scoreboard: wait for a result, compare with the oldest expected value, optionally hold
  // off sum_ready for a while, then complete the handshake.
  task automatic collect(input string tag, input int hold);
    logic [W-1:0] e;
    int budget;
    budget = 0;
    while (sum_valid !== 1'b1 && budget < 20) begin
      step();
      budget++;
    end
    chk({tag, "_valid"}, 32'(sum_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:4]));
    chk({tag, "_words"}, 32'(sum_words), 32'(e[3:0]));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_sum"}, 32'(sum), 32'(e[W-1:4]));
      chk({tag, "_hold_words"}, 32'(sum_words), 32'(e[3:0]));
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    chk({tag, "_idle"}, 32'(state_o), 32'd0);
    chk({tag, "_post_valid"}, 32'(sum_valid), 32'd0);
    chk({tag, "_post_sum"}, 32'(sum), 32'd0);
  endtask

  initial begin
    logic [6:0] w;
    int tot, n, len;
    logic [6:0] burst33[4];
    burst33[0] = 7'b1010011;
    burst33[1] = 7'b0111101;
    burst33[2] = 7'b1111111;
    burst33[3] = 7'b0000111;
    rst = 1'b1; in_valid = 1'b0; in_data = 7'd0; flush = 1'b0; sum_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(sum_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_words", 32'(sum_words), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    rst = 1'b0;
    step();

    // Full burst: valid must be up right after the 4th accepting edge.
    exp_q.push_back(pack(19, 4));
    for (int i = 0; i < 4; i++) send_word(burst33[i], 1'b0);
    chk("burst_valid_now", 32'(sum_valid), 32'd1);
    chk("burst_ready_low", 32'(in_ready), 32'd0);
    collect("burst", 0);

    // Early flush with a word in the same cycle.
    exp_q.push_back(pack(3, 2));
    send_word(7'b1000010, 1'b0);
    send_word(7'b0010000, 1'b1);
    chk("flush_valid_now", 32'(sum_valid), 32'd1);
    collect("flush", 0);

    // Backpressure on a random burst.
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      w = 7'($urandom_range(0, 127));
      tot += $countones(w);
      send_word(w, 1'b0);
    end
    exp_q.push_back(pack(tot, 4));
    collect("bp", 5);

    // Overflow: 28 ones fits in 5 bits but not in the 4-bit instance.
    exp_q.push_back(pack(28, 4));
    for (int i = 0; i < 4; i++) send_word(7'h7f, 1'b0);
`ifdef ONESCOUNT_SAT_EN
    chk("narrow_sum", 32'(s_sum), 32'd15);
`else
    chk("narrow_sum", 32'(s_sum), 32'd12);
`endif
    chk("narrow_valid", 32'(s_sum_valid), 32'd1);
    chk("narrow_words", 32'(s_sum_words), 32'd4);
    collect("wide", 0);

    // Reset mid-burst acts without a clock edge.
    send_word(7'h55, 1'b0);
    send_word(7'h2a, 1'b0);
    chk("mid_state", 32'(state_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk("mid_rst_valid", 32'(sum_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();
    exp_q.push_back(pack(4, 4));
    for (int i = 0; i < 4; i++) send_word(7'b0010000, 1'b0);
    collect("after_rst", 0);

    // Reset during OUTPUT discards the pending result.
    for (int i = 0; i < 4; i++) send_word(7'h0f, 1'b0);
    chk("pend_valid", 32'(sum_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("pend_rst_valid", 32'(sum_valid), 32'd0);
    chk("pend_rst_sum", 32'(sum), 32'd0);
    chk("pend_rst_words", 32'(sum_words), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pend_no_output", 32'(sum_valid), 32'd0);

    // Flush in IDLE is ignored; gaps between words hold the burst.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("idle_flush_state", 32'(state_o), 32'd0);
    exp_q.push_back(pack(19, 4));
    for (int i = 0; i < 4; i++) begin
      send_word(burst33[i], 1'b0);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) step();
        chk("gap_state", 32'(state_o), 32'd1);
        chk("gap_valid", 32'(sum_valid), 32'd0);
      end
    end
    collect("gaps", 0);

    // Random bursts, shorter ones closed by a flush on their last word.
    for (int b = 0; b < 6; b++) begin
      len = $urandom_range(1, 4);
      tot = 0;
      n   = 0;
      for (int i = 0; i < len; i++) begin
        w = 7'($urandom_range(0, 127));
        tot += $countones(w);
        n++;
        send_word(w, (i == len - 1) && (len < 4) && (len > 1));
      end
      if (len == 1) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      exp_q.push_back(pack(tot, n));
      collect("rand", $urandom_range(0, 2));
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
